alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised multi-cycle integer ALU and the next-generation execute unit of the 32-bit datapath. Single-cycle ops (add, sub, logic) complete in one clock. Unsigned multiply and divide run as WIDTH-step iterative shift-add and restoring-divide sequences behind a start/valid handshake. The control unit stalls on `busy` and captures `c` and the flags when `valid` pulses.

## Interface
- `WIDTH`, 32: operand/result width; any value ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; do not override).
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `op`  in  4: operation code (`alu_pkg::alu_op_t`).
- `a`, `b`  in  WIDTH: operands, captured on the accepting edge.
- `c`  out  WIDTH: result, held until the next completion.
- `valid`  out  1: one-cycle pulse; `c`/flags are new.
- `busy`  out  1: iterative op in flight.
- `zero`  out  1: `c`==0.
- `overflow`  out  1: signed overflow (ADD/SUB only, else 0).
- `div_zero`  out  1: DIV/REM with `b`==0.

## Operation
- Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, MULLO=5, MULHI=6, DIV=7, REM=8. Codes 9-15 are illegal.
- States:
  - IDLE: accepts `start`.
  - RUN: iterative step each clock.
  - Single-cycle ops never leave IDLE.
- IDLE + `start` + single-cycle op:
  - `c`/flags registered on the same edge; `valid`=1 next cycle.
  - Illegal op gives `c`=0, `valid`=1.
- IDLE + `start` + MUL/DIV/REM:
  - Latch `a`, `b`, op; clear accumulator; count=0; go to RUN; `busy`=1.
- RUN:
  - MUL step: if multiplier LSB, add multiplicand to the 2·WIDTH-bit accumulator; shift right.
  - DIV step: shift partial remainder left, bring in the dividend MSB, trial-subtract `b`, set the quotient bit on non-negative.
  - After step WIDTH: register `c` (MULLO low half, MULHI high half, DIV quotient, REM remainder) and flags. `valid`=1, `busy`=0, state IDLE.
- Divide by zero: no iteration shortcut; the restoring algorithm naturally yields quotient all-ones and remainder = `a`. `div_zero`=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `overflow` = signed overflow: operand MSBs equal and result MSB differs (SUB uses inverted `b`).
- `start` while `busy`=1 is ignored; no queueing.
- Flags update only on completion, together with `c`.

## Timing
- Reset values: `c`=0, `valid`=0, `busy`=0, `zero`=0, `overflow`=0, `div_zero`=0, state IDLE, counter 0.
- Latency, with the accepting edge as edge 0:
  - single-cycle ops: `valid` high after edge 0 (latency 1).
  - MUL/DIV/REM: `busy` high after edges 0..WIDTH-1; `valid` high after edge WIDTH (latency WIDTH).
- `valid` is high exactly one cycle.
- `start` may be asserted in the `valid` cycle; back-to-back issue has no bubble.
- Reset asserted mid-RUN aborts immediately with no `valid`; all outputs take reset values asynchronously.
- Operands may change after the accepting edge without affecting the result.

## Structure
- `alu_pkg`: `alu_op_t` enum, `state_t` {IDLE, RUN}, helper `is_iterative(op)`.
- Sub-module `muldiv_iter`: owns the accumulator, shift registers and counter.
  - Inputs: `load`, `is_div`, operands.
  - Outputs: `lo`, `hi`, `done`.
- Top level: FSM, single-cycle datapath, result/flag registers, output mux.

## Test plan
- ADD a=0xFFFFFFFF, b=1 -> `c`=0, `zero`=1, `overflow`=0, `valid` one cycle after start.
- SUB a=0x80000000, b=1 -> `c`=0x7FFFFFFF, `overflow`=1. XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
- MULLO then MULHI, a=b=0xFFFFFFFF:
  - `c`=0x00000001, then 0xFFFFFFFE.
  - `valid` exactly 32 cycles after each accept; `busy` high 32 cycles.
- DIV 100/7 -> `c`=14; REM 100/7 -> `c`=2. DIV 5/0 -> `c`=0xFFFFFFFF, `div_zero`=1; REM 5/0 -> `c`=5.
- Pulse `start` with ADD mid-MUL -> ignored; MUL result correct. Assert reset at cycle 10 of a DIV -> no `valid`, all outputs 0. Next op completes normally.
- WIDTH=8: MULHI 0xFF·0xFF -> 0xFE, latency 8. Back-to-back DIV issued in the `valid` cycle -> second `valid` 8 cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle ALU: op codes, FSM state
// encoding and the single-cycle / iterative op classification.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_MULLO = 4'd5,
        OP_MULHI = 4'd6,
        OP_DIV   = 4'd7,
        OP_REM   = 4'd8
    } alu_op_t;

    typedef logic state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op >= 4'(OP_MULLO)) && (op <= 4'(OP_REM));
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == 4'(OP_DIV)) || (op == 4'(OP_REM));
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// hi/lo register pair: hi = accumulator or remainder, lo = multiplier or quotient.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             run_reg;
    logic             is_div_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        rem_sh  = {hi_reg, lo_reg[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_reg};
        if (is_div_reg) begin
            // diff[WIDTH] set means the trial subtraction went negative: restore.
            hi_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // Post-step values are exported so the caller can capture the final
    // result on the same edge that performs the last step.
    assign lo   = lo_next;
    assign hi   = hi_next;
    assign done = run_reg && (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            is_div_reg <= 1'b0;
        end else if (load) begin
            hi_reg     <= '0;
            lo_reg     <= a;
            b_reg      <= b;
            cnt_reg    <= '0;
            run_reg    <= 1'b1;
            is_div_reg <= is_div;
        end else if (run_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute unit: single-cycle add/sub/logic plus iterative mul/div behind a
// start/busy/valid handshake; result and flags are held until the next completion.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             valid,
    output logic             busy,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic             b_zero_reg;
    logic [WIDTH-1:0] c_reg;
    logic             valid_reg, zero_reg, overflow_reg, div_zero_reg;

    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic [WIDTH-1:0] it_result;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_done;
    logic             md_load;

    assign md_load = (state_reg == IDLE) && start && is_iterative(op);

    muldiv_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (is_divide(op)),
        .a      (a),
        .b      (b),
        .lo     (md_lo),
        .hi     (md_hi),
        .done   (md_done)
    );

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = a + b;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = a - b;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        case (op_reg)
            OP_MULLO, OP_DIV: it_result = md_lo;
            default:          it_result = md_hi;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            b_zero_reg   <= 1'b0;
            c_reg        <= '0;
            valid_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    if (is_iterative(op)) begin
                        state_reg  <= RUN;
                        op_reg     <= op;
                        b_zero_reg <= (b == '0);
                    end else begin
                        c_reg        <= sc_result;
                        zero_reg     <= (sc_result == '0);
                        overflow_reg <= sc_ovf;
                        div_zero_reg <= 1'b0;
                        valid_reg    <= 1'b1;
                    end
                end
            end else if (md_done) begin
                c_reg        <= it_result;
                zero_reg     <= (it_result == '0);
                overflow_reg <= 1'b0;
                div_zero_reg <= b_zero_reg && is_divide(op_reg);
                valid_reg    <= 1'b1;
                state_reg    <= IDLE;
            end
        end
    end

    assign c        = c_reg;
    assign valid    = valid_reg;
    assign busy     = (state_reg == RUN);
    assign zero     = zero_reg;
    assign overflow = overflow_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit and an 8-bit instance share one
// stimulus bus selected by sel8; expected values are hand-computed constants.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sel8 = 1'b0;

    logic [31:0] c32;
    logic        valid32, busy32, zero32, ovf32, dz32;
    logic [7:0]  c8;
    logic        valid8, busy8, zero8, ovf8, dz8;

    logic [31:0] c_s;
    logic        valid_s, busy_s, zero_s, ovf_s, dz_s;

    int checks = 0;
    int failures = 0;
    int edge_idx, busy_cnt, vcnt;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst_n), .start(start && !sel8), .op(op), .a(a), .b(b),
        .c(c32), .valid(valid32), .busy(busy32), .zero(zero32),
        .overflow(ovf32), .div_zero(dz32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start && sel8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .c(c8), .valid(valid8), .busy(busy8), .zero(zero8),
        .overflow(ovf8), .div_zero(dz8)
    );

    assign c_s     = sel8 ? {24'd0, c8} : c32;
    assign valid_s = sel8 ? valid8 : valid32;
    assign busy_s  = sel8 ? busy8  : busy32;
    assign zero_s  = sel8 ? zero8  : zero32;
    assign ovf_s   = sel8 ? ovf8   : ovf32;
    assign dz_s    = sel8 ? dz8    : dz32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edge index (0 = accepting edge) at which valid appears, -1 on timeout.
    task automatic wait_done(output int eidx, output int bcnt);
        eidx = -1;
        bcnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (valid_s) begin
                eidx = k;
                break;
            end
            if (busy_s) bcnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_c, input int exp_edge);
        int e, bc;
        issue(o, av, bv);
        wait_done(e, bc);
        $display("txn %s op=%0d a=0x%0h b=0x%0h c=0x%0h edge=%0d busy_cycles=%0d",
                 tag, o, av, bv, c_s, e, bc);
        chk({tag, "_c"}, c_s, exp_c);
        chk({tag, "_edge"}, 32'(e), 32'(exp_edge));
        chk({tag, "_busy"}, 32'(bc), 32'(exp_edge));
        @(negedge clk);
        chk({tag, "_valid_drop"}, {31'd0, valid_s}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_c", c32, 32'd0);
        chk("rst_valid", {31'd0, valid32}, 32'd0);
        chk("rst_busy", {31'd0, busy32}, 32'd0);
        chk("rst_zero", {31'd0, zero32}, 32'd0);
        chk("rst_ovf", {31'd0, ovf32}, 32'd0);
        chk("rst_dz", {31'd0, dz32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        chk("add_zero", {31'd0, zero_s}, 32'd1);
        chk("add_ovf", {31'd0, ovf_s}, 32'd0);

        run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0);
        chk("sub_ovf_flag", {31'd0, ovf_s}, 32'd1);
        chk("sub_zero", {31'd0, zero_s}, 32'd0);

        run_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0);
        run_op("illegal", 4'd12, 32'h1234, 32'h5678, 32'd0, 0);

        run_op("mullo", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
        run_op("mulhi", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);

        run_op("div", 4'd7, 32'd100, 32'd7, 32'd14, 32);
        chk("div_dz", {31'd0, dz_s}, 32'd0);
        run_op("rem", 4'd8, 32'd100, 32'd7, 32'd2, 32);
        run_op("div0", 4'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 32);
        chk("div0_dz", {31'd0, dz_s}, 32'd1);
        run_op("rem0", 4'd8, 32'd5, 32'd0, 32'd5, 32);
        chk("rem0_dz", {31'd0, dz_s}, 32'd1);

        // start with ADD while a multiply is running must be ignored
        issue(4'd5, 32'd1234, 32'd5678);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edge_idx, busy_cnt);
        $display("txn mul_ignore c=0x%0h edge=%0d", c_s, edge_idx);
        chk("mul_ignore_c", c_s, 32'd7006652);
        chk("mul_ignore_edge", 32'(edge_idx), 32'd28);

        // Reset in the middle of a divide
        issue(4'd7, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        $display("txn div_abort c=0x%0h busy=%0d valid=%0d", c32, busy32, valid32);
        chk("abort_c", c32, 32'd0);
        chk("abort_busy", {31'd0, busy32}, 32'd0);
        chk("abort_valid", {31'd0, valid32}, 32'd0);
        chk("abort_zero", {31'd0, zero32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid32) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 32'd0);
        run_op("after_abort", 4'd0, 32'd2, 32'd3, 32'd5, 0);

        // 8-bit instance
        sel8 = 1'b1;
        run_op("w8_mulhi", 4'd6, 32'hFF, 32'hFF, 32'hFE, 8);

        issue(4'd7, 32'd200, 32'd9);
        wait_done(edge_idx, busy_cnt);
        $display("txn w8_div1 c=0x%0h edge=%0d", c_s, edge_idx);
        chk("w8_div1_c", c_s, 32'd22);
        chk("w8_div1_edge", 32'(edge_idx), 32'd8);
        start = 1'b1; op = 4'd7; a = 32'd50; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(edge_idx, busy_cnt);
        $display("txn w8_div2 c=0x%0h edge=%0d", c_s, edge_idx);
        chk("w8_div2_c", c_s, 32'd7);
        chk("w8_div2_edge", 32'(edge_idx), 32'd8);
        chk("w8_div2_busy", 32'(busy_cnt), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
